// File: rtl/usb_tx_phy_if.sv
// Byte-feed handshake between a transmit FIFO and the USB transmit PHY.
// Handshake: tx_valid high means tx_data holds a byte; the PHY pulses
// tx_strobe for one cycle in the cycle it takes tx_data, and the FIFO
// advances on that pulse. tx_data is only meaningful while tx_valid is high.
interface usb_tx_phy_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_strobe;

   // FIFO side
   modport master (output tx_data, output tx_valid, input tx_strobe);
   // PHY side
   modport slave  (input tx_data, input tx_valid, output tx_strobe);
endinterface

// File: rtl/usb_tx_phy.sv
// USB full-speed transmit PHY: SYNC, NRZI-encoded bit-stuffed payload, EOP.
// Bytes are pulled from a FIFO one at a time; the packet ends when the FIFO
// has no byte ready at a byte boundary.
module usb_tx_phy #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   usb_tx_phy_if.slave        tx_if,
   output logic               usb_dp,
   output logic               usb_dn,
   output logic               usb_oe,
   output logic               busy,
   output logic [2:0]         dbg_state
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      DATA    = 3'd2,
      EOP_SE0 = 3'd3,
      EOP_J   = 3'd4
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cyc;      // cycle within the current bit period
   logic [2:0]    r_bit_cnt;  // index of the last data bit sent (or EOP period)
   logic [2:0]    r_ones;     // consecutive ones, drives bit stuffing
   logic [7:0]    r_byte;     // byte being sent (0x80 during SYNC)
   logic          r_line;     // NRZI line level: 1 = J, 0 = K

   state_t        w_state_nx;
   logic [CW-1:0] w_cyc_nx;
   logic [2:0]    w_bit_cnt_nx;
   logic [2:0]    w_ones_nx;
   logic [7:0]    w_byte_nx;
   logic          w_line_nx;
   logic          w_strobe;
   logic          w_start_bit;
   logic          w_bit_val;
   logic          w_period_end;
   logic [2:0]    w_next_idx;

   assign w_period_end = (r_cyc == LAST_CYC);
   assign w_next_idx   = r_bit_cnt + 3'd1;

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cyc     <= '0;
         r_bit_cnt <= '0;
         r_ones    <= '0;
         r_byte    <= '0;
         r_line    <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_cyc     <= w_cyc_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_ones    <= w_ones_nx;
         r_byte    <= w_byte_nx;
         r_line    <= w_line_nx;
      end
   end

   // Next-state logic: bit timing, byte boundaries, stuffing and NRZI.
   always_comb begin
      w_state_nx   = r_state;
      w_cyc_nx     = w_period_end ? '0 : r_cyc + CW'(1);
      w_bit_cnt_nx = r_bit_cnt;
      w_ones_nx    = r_ones;
      w_byte_nx    = r_byte;
      w_line_nx    = r_line;
      w_strobe     = 1'b0;
      w_start_bit  = 1'b0;
      w_bit_val    = 1'b0;

      case (r_state)
         IDLE: begin
            w_cyc_nx  = '0;
            w_line_nx = 1'b1;
            if (tx_if.tx_valid) begin
               // SYNC is 0x80 LSB first; its first bit is a 0, which also
               // clears the ones counter.
               w_state_nx   = SYNC;
               w_bit_cnt_nx = '0;
               w_byte_nx    = 8'h80;
               w_start_bit  = 1'b1;
               w_bit_val    = 1'b0;
            end
         end
         SYNC, DATA: begin
            if (w_period_end) begin
               if (r_ones == 3'd6) begin
                  // Stuffed zero; the byte position does not advance, so a
                  // stuff after bit 7 delays the byte boundary by one period.
                  w_start_bit = 1'b1;
                  w_bit_val   = 1'b0;
               end else if (r_bit_cnt == 3'd7) begin
                  w_bit_cnt_nx = '0;
                  if (tx_if.tx_valid) begin
                     w_strobe    = 1'b1;
                     w_state_nx  = DATA;
                     w_byte_nx   = tx_if.tx_data;
                     w_start_bit = 1'b1;
                     w_bit_val   = tx_if.tx_data[0];
                  end else begin
                     w_state_nx = EOP_SE0;
                  end
               end else begin
                  w_bit_cnt_nx = w_next_idx;
                  w_start_bit  = 1'b1;
                  w_bit_val    = r_byte[w_next_idx];
               end
            end
         end
         EOP_SE0: begin
            w_line_nx = 1'b1;
            if (w_period_end) begin
               if (r_bit_cnt == 3'd1) begin
                  w_state_nx   = EOP_J;
                  w_bit_cnt_nx = '0;
               end else begin
                  w_bit_cnt_nx = r_bit_cnt + 3'd1;
               end
            end
         end
         EOP_J: begin
            w_line_nx = 1'b1;
            if (w_period_end) begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase

      // NRZI: a zero toggles the line, a one holds it and counts toward a stuff.
      if (w_start_bit) begin
         if (w_bit_val) begin
            w_ones_nx = r_ones + 3'd1;
         end else begin
            w_ones_nx = '0;
            w_line_nx = ~r_line;
         end
      end
   end

   // Line drive decoded from the registered state.
   always_comb begin
      usb_dp = 1'b1;
      usb_dn = 1'b0;
      case (r_state)
         SYNC, DATA: begin
            usb_dp = r_line;
            usb_dn = ~r_line;
         end
         EOP_SE0: begin
            usb_dp = 1'b0;
            usb_dn = 1'b0;
         end
         default: begin
            usb_dp = 1'b1;
            usb_dn = 1'b0;
         end
      endcase
   end

   assign usb_oe          = (r_state != IDLE);
   assign busy            = (r_state != IDLE);
   assign tx_if.tx_strobe = w_strobe & ~reset;
   assign dbg_state       = r_state;

endmodule

// File: doc/usb_tx_phy.md
USB_TX_PHY -- requirements
Module: usb_tx_phy

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per USB bit period (48 MHz clk -> 12 Mb/s full speed); legal values are >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port tx_data, input, 8, the byte to transmit, sent LSB first.
REQ-005 The block SHALL have port tx_valid, input, 1, high when tx_data holds a byte; it connects directly to a FIFO data_available output.
REQ-006 The block SHALL have port tx_strobe, output, 1, a one-cycle pulse when tx_data is consumed; it connects directly to a FIFO read_strobe input.
REQ-007 The block SHALL have port usb_dp, output, 1, the D+ drive value.
REQ-008 The block SHALL have port usb_dn, output, 1, the D- drive value.
REQ-009 The block SHALL have port usb_oe, output, 1, high while the block drives the bus.
REQ-010 The block SHALL have port busy, output, 1, high from packet start until the block returns to IDLE.

Function
REQ-011 Line states SHALL be: J = dp1/dn0, K = dp0/dn1, SE0 = dp0/dn0.
REQ-012 The state machine SHALL have states IDLE, SYNC, DATA, EOP_SE0 and EOP_J.
REQ-013 In IDLE, outputs SHALL be dp=1, dn=0, oe=0 and busy=0.
REQ-014 When in IDLE and tx_valid=1 is sampled, the next cycle SHALL enter SYNC with oe=1 and busy=1, and SHALL drive the first SYNC bit; SYNC does not consume a byte.
REQ-015 Every transmitted bit, including stuff bits, SHALL hold its line state for exactly CLKS_PER_BIT cycles.
REQ-016 SYNC SHALL be the byte 0x80 sent LSB first, giving line KJKJKJKK from a J idle.
REQ-017 NRZI encoding SHALL be applied: a 0 bit toggles J<->K and a 1 bit holds the current line state.
REQ-018 Bit stuffing: a ones counter SHALL reset to 0 at SYNC entry, increment on each 1 bit (SYNC bits included), and clear on each 0 bit.
REQ-019 When the ones counter reaches 6, a stuffed 0 bit period SHALL be inserted before the next data bit and the counter SHALL be cleared.
REQ-020 A stuff bit SHALL also be inserted when the sixth 1 is the last bit of a byte or the last bit before EOP.
REQ-021 The byte-boundary cycle SHALL be the last clock of the final bit period of SYNC or of the current byte, counted after any trailing stuff bit.
REQ-022 At the byte-boundary cycle with tx_valid=1, tx_strobe SHALL be 1 for that cycle, tx_data SHALL be latched, and bit 0 of the new byte SHALL start on the next cycle.
REQ-023 At the byte-boundary cycle with tx_valid=0, the block SHALL enter EOP_SE0 on the next cycle and SHALL NOT pulse tx_strobe.
REQ-024 tx_strobe SHALL never assert outside a byte-boundary cycle, and SHALL assert at most once per byte.
REQ-025 EOP_SE0 SHALL drive SE0 for 2 bit periods, then EOP_J SHALL drive J for 1 bit period, all with oe=1.
REQ-026 After EOP_J the block SHALL enter IDLE, with oe=0 and busy=0 on that cycle.
REQ-027 A new packet SHALL start no earlier than the cycle after IDLE is entered, even if tx_valid stays high.
REQ-028 The block SHALL read tx_data only during strobe cycles.

Reset
REQ-029 reset=1 SHALL force, on the next clock edge, state=IDLE, dp=1, dn=0, oe=0, tx_strobe=0, busy=0, and clear the ones counter, bit counter and cycle counter.
REQ-030 reset SHALL take priority over all other activity, including mid-packet, and SHALL NOT complete the EOP.

Verification
REQ-031 Bench SHALL check: reset held 3 cycles with tx_valid=1 -> dp=1, dn=0, oe=0, tx_strobe=0 and busy=0 throughout.
REQ-032 Bench SHALL check: single byte 0x00, tx_valid dropped after the strobe, CLKS_PER_BIT=4 -> line KJKJKJKK JKJKJKJK SE0 SE0 J, oe high for 76 cycles, and exactly one tx_strobe pulse, on the last cycle of SYNC.
REQ-033 Bench SHALL check: single byte 0xFF -> after SYNC the line is K K K K K J J J J (stuff bit after the fifth data 1), then SE0 SE0 J, 20 bit periods total.
REQ-034 Bench SHALL check: back-to-back bytes 0xA5 and 0x3C from a FIFO -> tx_strobe pulses 32 cycles apart, then EOP, and the FIFO ends empty.
REQ-035 Bench SHALL check: reset asserted at the 3rd bit of a data byte -> the next cycle shows oe=0, dp=1, dn=0 and busy=0; a following packet is bit-exact to REQ-032.
